// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the MEM-stage data-memory request port.
// Word RAM with LATENCY wait states; misaligned accesses return err.
//
// Ports:
//   clk, rst         clock (rising edge), async active-low reset
//   req, wr, size    request valid, write/read, 0=byte 1=half 2/3=word
//   addr, wdata      byte address, lane-aligned write data
//   wstrb            byte-lane write enables
//   addr_ok          request accepted this cycle (IDLE only)
//   data_ok          one-cycle response pulse
//   rdata, err       read word / misalign flag, valid with data_ok
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam bit NO_WAIT = (LATENCY == 0);

  state_t state;
  state_t state_nx;

  logic [3:0]  cnt;
  logic        l_wr;
  logic [1:0]  l_size;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_wstrb;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        wait_done;
  logic        access;
  logic        mis;
  logic        commit;

  logic        a_wr;
  logic [1:0]  a_size;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic [AW-1:0] idx;

  logic [31:0] rdata_q;
  logic        err_q;
  logic        unused_addr;

  assign accept    = req & addr_ok;
  assign wait_done = (state == WAIT) && (cnt <= 4'd1);
  assign access    = (accept & NO_WAIT) | wait_done;

  // With no wait states the access happens on the accept edge,
  // so it must use the live request fields instead of the latch.
  always_comb begin
    if (state == IDLE) begin
      a_wr    = wr;
      a_size  = size;
      a_addr  = addr;
      a_wdata = wdata;
      a_wstrb = wstrb;
    end else begin
      a_wr    = l_wr;
      a_size  = l_size;
      a_addr  = l_addr;
      a_wdata = l_wdata;
      a_wstrb = l_wstrb;
    end
  end

  assign idx = a_addr[AW+1:2];
  assign unused_addr = ^{a_addr[31:AW+2]};

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      a_size == 2'd0: mis = 1'b0;
      a_size == 2'd1: mis = a_addr[0];
      default:        mis = (a_addr[1:0] != 2'b00);
    endcase
  end

  // Gated by rst so an edge during reset never touches the RAM.
  assign commit = access & a_wr & ~mis & rst;

  always_comb begin
    state_nx = state;
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        addr_ok = 1'b1;
        if (req) begin
          state_nx = NO_WAIT ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_done) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        data_ok  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      l_wr    <= 1'b0;
      l_size  <= 2'd0;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      l_wstrb <= 4'd0;
    end else if (accept) begin
      cnt     <= LAT;
      l_wr    <= wr;
      l_size  <= size;
      l_addr  <= addr;
      l_wdata <= wdata;
      l_wstrb <= wstrb;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q <= mis;
      if (mis || a_wr) begin
        rdata_q <= 32'd0;
      end else begin
        rdata_q <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && a_wstrb[i]) begin
        mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Slave end of the CPU data-memory request interface that the pipeline controller and datapath drive in the MEM stage.
- Accepts one SRAM-like request at a time: read, or byte-masked write.
- Models a word-organised data RAM with a programmable number of wait states, and returns read data or a write acknowledge with a data_ok handshake.
- Flags misaligned accesses with err instead of performing them.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; must be a power of two.
- AW, 10, word-index width; AW = log2(DEPTH).
- LATENCY, 2, wait-state cycles between request accept and response; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- addr  in  32  byte address.
- wdata  in  32  write data, already lane-aligned.
- wstrb  in  4  byte-lane write enables.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  response valid, one-cycle pulse.
- rdata  out  32  full read word; extraction and sign-extension are done by the pipeline.
- err  out  1  misaligned access; qualified by data_ok.

Behaviour:
- Single outstanding transaction. FSM states: IDLE, WAIT, RESP.
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, data_ok=0, rdata=0, err=0, all latched request fields cleared.
  - RAM contents are not reset.
  - Reset during WAIT or RESP aborts the transaction: no write is committed and no data_ok is issued.
- addr_ok is combinational: 1 only when state==IDLE, regardless of req.
- Accept: req & addr_ok sampled at a rising edge T.
  - Latch wr, size, addr, wdata, wstrb.
  - counter <= LATENCY.
  - Next state is WAIT if LATENCY>0, else it goes straight to the access cycle.
- WAIT: counter decrements each cycle. When counter reaches 1, perform the access and enter RESP.
- Access cycle (registered):
  - Word index = addr[AW+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Misaligned if size==1 & addr[0], or size>=2 & addr[1:0]!=0. On misalign: err<=1, rdata<=0, no RAM update.
  - Read: rdata <= RAM[index], err <= 0.
  - Write: for each lane i with wstrb[i]=1, RAM[index][8i+7:8i] <= wdata[8i+7:8i]; rdata <= 0, err <= 0. wstrb=0 is a legal no-op write that is still acknowledged.
- RESP:
  - data_ok=1 for exactly one cycle, visible in the cycle after edge T+LATENCY.
  - rdata and err are valid while data_ok=1 and hold their value until the next response.
  - Next state is IDLE.
- Request-to-response latency is LATENCY+1 cycles from accept edge to the data_ok cycle.
- Back-to-back: the next request is accepted in the cycle after the data_ok cycle, so the minimum turnaround is LATENCY+2 cycles per access.
- req while not IDLE: ignored with addr_ok=0. The requester must hold req and its fields until addr_ok.
- Read-after-write to the same word returns the written data because the write commits before the next accept.

Test Plan:
- LATENCY=2, reset release, then read addr 0x0 -> addr_ok=1 at accept, data_ok high exactly 3 cycles later, rdata=0x00000000 after the RAM is preloaded with zeros.
- Write word 0x12345678 with wstrb=4'b1111 to 0x10, then byte write 0x000000AB with wstrb=4'b0001 to 0x10, then read 0x10 -> rdata=0x123456AB, err=0.
- Halfword read at addr 0x13 -> data_ok with err=1, rdata=0. A following word read of 0x10 shows the contents unchanged.
- Hold req=1 continuously for 3 reads -> addr_ok pulses every 4 cycles, three data_ok pulses, never two outstanding.
- Assert rst=0 while in WAIT during a write to 0x20, then read 0x20 after release -> old contents returned, no spurious data_ok during or after reset.
- LATENCY=0 build: read accepted at edge T -> data_ok in the cycle after T. Write to addr 0x1000 with DEPTH=1024 aliases to word 0, confirmed by reading 0x0.
